// File: rtl/ptp_us_pkg.sv
// Shared ultrasonic PTP definitions: receiver state encoding and timing defaults
// used by the piezo receive front-end and the PTP master/slave engines.
package ptp_us_pkg;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_QUALIFY = 2'd1,
    RX_HOLDOFF = 2'd2,
    RX_BLANK   = 2'd3
  } rx_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_MIN_EDGES      = 4;
  localparam int DEF_EDGE_WINDOW    = 2000;
  localparam int DEF_HOLDOFF_CYCLES = 10000;
  localparam int DEF_BLANK_CYCLES   = 8000;
  localparam int DEF_CNT_W          = 16;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piezo_sync_edge.sv
// Multi-flop synchroniser for the asynchronous piezo comparator plus a
// rising-edge detector on the synchronised level.
module piezo_sync_edge
  import ptp_us_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic piezo_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], piezo_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/piezo_rx_detector.sv
// Ultrasonic burst qualifier: counts closely spaced comparator edges, blanks
// around own transmissions, suppresses ring-down and emits one arrival strobe.
module piezo_rx_detector
  import ptp_us_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int MIN_EDGES      = DEF_MIN_EDGES,
  parameter int EDGE_WINDOW    = DEF_EDGE_WINDOW,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             piezo_in,
  input  logic             tx_active,
  input  logic             clear_stats,
  output logic             detect_pulse,
  output logic             busy,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] burst_count,
  output logic [CNT_W-1:0] reject_count
);

  localparam int EDGE_W  = cntWidth(MIN_EDGES);
  localparam int GAP_W   = cntWidth(EDGE_WINDOW);
  localparam int HOLD_W  = cntWidth(HOLDOFF_CYCLES);
  localparam int BLANK_W = cntWidth(BLANK_CYCLES);

  rx_state_t          state_q, state_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               detect_q, detect_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [CNT_W-1:0]   reject_q, reject_d;
  logic               syncLevel, syncRise, rise;
  logic               burstInc, rejectInc;

  piezo_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .piezo_i(piezo_in),
    .sync_o (syncLevel),
    .rise_o (syncRise)
  );

  assign rise = syncRise & syncLevel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      edge_q   <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
      blank_q  <= '0;
      detect_q <= 1'b0;
      burst_q  <= '0;
      reject_q <= '0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
      blank_q  <= blank_d;
      detect_q <= detect_d;
      burst_q  <= burst_d;
      reject_q <= reject_d;
    end
  end

  // Own transmission overrides everything, then enable, then normal sequencing.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    blank_d   = blank_q;
    detect_d  = 1'b0;
    burstInc  = 1'b0;
    rejectInc = 1'b0;
    if (tx_active) begin
      state_d = RX_BLANK;
      edge_d  = '0;
      gap_d   = '0;
      hold_d  = '0;
      blank_d = '0;
    end else if (!enable) begin
      state_d = RX_IDLE;
      edge_d  = '0;
      gap_d   = '0;
      hold_d  = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (rise) begin
            if (MIN_EDGES == 1) begin
              detect_d = 1'b1;
              burstInc = 1'b1;
              state_d  = RX_HOLDOFF;
              hold_d   = '0;
            end else begin
              state_d = RX_QUALIFY;
              edge_d  = EDGE_W'(1);
              gap_d   = '0;
            end
          end
        end
        RX_QUALIFY: begin
          if (rise) begin
            gap_d = '0;
            if (edge_q == EDGE_W'(MIN_EDGES - 1)) begin
              detect_d = 1'b1;
              burstInc = 1'b1;
              state_d  = RX_HOLDOFF;
              hold_d   = '0;
              edge_d   = '0;
            end else begin
              edge_d = edge_q + EDGE_W'(1);
            end
          end else if (gap_q == GAP_W'(EDGE_WINDOW - 1)) begin
            rejectInc = 1'b1;
            state_d   = RX_IDLE;
            edge_d    = '0;
            gap_d     = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        RX_HOLDOFF: begin
          if (hold_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
            state_d = RX_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        RX_BLANK: begin
          if (blank_q == BLANK_W'(BLANK_CYCLES - 1)) begin
            state_d = RX_IDLE;
            blank_d = '0;
          end else begin
            blank_d = blank_q + BLANK_W'(1);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // A clear in the same cycle as an increment leaves the counter at zero.
  always_comb begin
    burst_d  = burst_q;
    reject_d = reject_q;
    if (burstInc) begin
      burst_d = burst_q + CNT_W'(1);
    end
    if (rejectInc) begin
      reject_d = reject_q + CNT_W'(1);
    end
    if (clear_stats) begin
      burst_d  = '0;
      reject_d = '0;
    end
  end

  assign detect_pulse = detect_q;
  assign busy         = (state_q != RX_IDLE);
  assign state_dbg    = state_q;
  assign burst_count  = burst_q;
  assign reject_count = reject_q;

endmodule

// File: tb/tb_piezo_rx_detector.sv
// Bench for piezo_rx_detector: directed scenarios plus randomized traffic, all
// compared every cycle against a timestamp-based behavioural model.
module tb_piezo_rx_detector;

  localparam int SYNC  = 2;
  localparam int MINE  = 3;
  localparam int EW    = 10;
  localparam int HOLD  = 20;
  localparam int BLANK = 15;
  localparam int CW    = 16;

  localparam int S_IDLE  = 0;
  localparam int S_QUAL  = 1;
  localparam int S_HOLD  = 2;
  localparam int S_BLANK = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          piezo_in = 1'b0;
  logic          tx_active = 1'b0;
  logic          clear_stats = 1'b0;
  logic          detect_pulse;
  logic          busy;
  logic [1:0]    state_dbg;
  logic [CW-1:0] burst_count;
  logic [CW-1:0] reject_count;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  int cyc = 0;
  bit hist[$];
  bit mRise;
  int mState = S_IDLE;
  int mEdges = 0;
  int mBurst = 0;
  int mReject = 0;
  bit mDetect = 1'b0;
  int lastRise = 0;
  int holdStart = 0;
  int txEdge = 0;

  int dutPulses = 0;
  int lastPulseCyc = 0;

  piezo_rx_detector #(
    .SYNC_STAGES(SYNC),
    .MIN_EDGES(MINE),
    .EDGE_WINDOW(EW),
    .HOLDOFF_CYCLES(HOLD),
    .BLANK_CYCLES(BLANK),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .piezo_in(piezo_in),
    .tx_active(tx_active),
    .clear_stats(clear_stats),
    .detect_pulse(detect_pulse),
    .busy(busy),
    .state_dbg(state_dbg),
    .burst_count(burst_count),
    .reject_count(reject_count)
  );

  always #5 clock = ~clock;

  initial begin
    repeat (SYNC + 1) hist.push_back(1'b0);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: raw samples delayed by the synchroniser, bursts judged by the
  // distance in cycles between accepted rises and absolute deadlines.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mState  = S_IDLE;
      mEdges  = 0;
      mBurst  = 0;
      mReject = 0;
      mDetect = 1'b0;
      foreach (hist[i]) hist[i] = 1'b0;
    end else begin
      cyc++;
      mRise = hist[SYNC-1] && !hist[SYNC];
      hist.push_front(piezo_in);
      void'(hist.pop_back());
      mDetect = 1'b0;
      if (tx_active) begin
        mState = S_BLANK;
        txEdge = cyc;
      end else if (!enable) begin
        mState = S_IDLE;
      end else begin
        case (mState)
          S_IDLE: if (mRise) begin
            mEdges   = 1;
            lastRise = cyc;
            mState   = S_QUAL;
          end
          S_QUAL: if (mRise) begin
            mEdges++;
            lastRise = cyc;
          end else if (cyc - lastRise >= EW) begin
            mState = S_IDLE;
            mReject++;
          end
          S_HOLD: if (cyc - holdStart >= HOLD) mState = S_IDLE;
          default: if (cyc - txEdge >= BLANK) mState = S_IDLE;
        endcase
        if (mState == S_QUAL && mEdges >= MINE) begin
          mDetect   = 1'b1;
          mBurst++;
          mState    = S_HOLD;
          holdStart = cyc;
        end
      end
      if (clear_stats) begin
        mBurst  = 0;
        mReject = 0;
      end
      mBurst  = mBurst % (1 << CW);
      mReject = mReject % (1 << CW);
    end
  end

  always @(negedge clock) begin
    if (started) begin
      checkOutput("detect_pulse", int'(detect_pulse), int'(mDetect));
      checkOutput("busy", int'(busy), (mState != S_IDLE) ? 1 : 0);
      checkOutput("state_dbg", int'(state_dbg), mState);
      checkOutput("burst_count", int'(burst_count), mBurst);
      checkOutput("reject_count", int'(reject_count), mReject);
      if (detect_pulse) begin
        dutPulses++;
        lastPulseCyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Send n one-cycle raw pulses, each followed by lowCycles low cycles.
  task automatic applyStimulus(input int n, input int lowCycles, output int lastK);
    lastK = 0;
    for (int i = 0; i < n; i++) begin
      lastK    = cyc + 1;
      piezo_in = 1'b1;
      tick();
      piezo_in = 1'b0;
      repeat (lowCycles) tick();
    end
  endtask

  initial begin
    int k;
    int hc;
    int tEdge;
    int txLeft;
    int enOff;

    @(posedge clock);
    started = 1'b1;
    #2;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_state", int'(state_dbg), 0);
    checkOutput("reset_burst", int'(burst_count), 0);
    tick();

    // Scenario 1: three rises 5 apart -> one pulse two edges after third sample.
    applyStimulus(2, 4, k);
    applyStimulus(1, 0, k);
    hc = 0;
    repeat (40) begin
      @(negedge clock);
      if (state_dbg == 2'd2) hc++;
    end
    checkOutput("s1_latency", lastPulseCyc - k, 2);
    checkOutput("s1_pulses", dutPulses, 1);
    checkOutput("s1_burst", int'(burst_count), 1);
    checkOutput("s1_holdoff_len", hc, HOLD);
    checkOutput("s1_idle", int'(state_dbg), 0);

    // Scenario 2: two rises then silence -> rejected partial burst.
    applyStimulus(2, 4, k);
    repeat (20) tick();
    @(negedge clock);
    checkOutput("s2_reject", int'(reject_count), 1);
    checkOutput("s2_burst", int'(burst_count), 1);
    checkOutput("s2_pulses", dutPulses, 1);
    checkOutput("s2_idle", int'(state_dbg), 0);

    // Scenario 3: six quick rises -> only one pulse.
    applyStimulus(6, 1, k);
    repeat (30) tick();
    @(negedge clock);
    checkOutput("s3_pulses", dutPulses, 2);
    checkOutput("s3_burst", int'(burst_count), 2);

    // Scenario 4a: burst too soon after transmit is blanked.
    tx_active = 1'b1;
    repeat (50) begin
      piezo_in = 1'($urandom_range(0, 1));
      tick();
    end
    @(negedge clock);
    checkOutput("s4_blank", int'(state_dbg), 3);
    tx_active = 1'b0;
    piezo_in  = 1'b0;
    tEdge     = cyc;
    repeat (9) tick();
    checkOutput("s4_first_edge", cyc + 1 - tEdge, 10);
    applyStimulus(3, 2, k);
    repeat (30) tick();
    @(negedge clock);
    checkOutput("s4a_pulses", dutPulses, 2);

    // Scenario 4b: same burst once the blank window has expired.
    tx_active = 1'b1;
    repeat (50) tick();
    tx_active = 1'b0;
    repeat (15) tick();
    applyStimulus(3, 2, k);
    repeat (30) tick();
    @(negedge clock);
    checkOutput("s4b_pulses", dutPulses, 3);
    checkOutput("s4b_burst", int'(burst_count), 3);

    // Scenario 5: reset in the middle of a partial burst.
    applyStimulus(2, 4, k);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("s5_pulse", int'(detect_pulse), 0);
    checkOutput("s5_busy", int'(busy), 0);
    checkOutput("s5_state", int'(state_dbg), 0);
    checkOutput("s5_burst", int'(burst_count), 0);
    checkOutput("s5_reject", int'(reject_count), 0);
    repeat (2) tick();
    reset = 1'b0;
    applyStimulus(1, 4, k);
    @(negedge clock);
    checkOutput("s5_qualify", int'(state_dbg), 1);
    checkOutput("s5_no_pulse", dutPulses, 3);
    repeat (20) tick();

    // Scenario 6: clear coincides with the qualifying rise.
    applyStimulus(2, 4, k);
    piezo_in = 1'b1;
    tick();
    piezo_in = 1'b0;
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    @(negedge clock);
    checkOutput("s6_pulse", int'(detect_pulse), 1);
    checkOutput("s6_burst", int'(burst_count), 0);
    repeat (30) tick();

    // Scenario 6b: enable dropped mid-qualify must not count a reject.
    applyStimulus(2, 4, k);
    enable = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    checkOutput("s6_disabled", int'(state_dbg), 0);
    enable = 1'b1;
    repeat (20) tick();
    @(negedge clock);
    checkOutput("s6_reject", int'(reject_count), 0);
    checkOutput("s6_burst_hold", int'(burst_count), 0);

    // Randomized traffic with dense and sparse phases.
    txLeft = 0;
    enOff  = 0;
    for (int i = 0; i < 4000; i++) begin
      if (txLeft > 0) begin
        tx_active = 1'b1;
        txLeft--;
      end else begin
        tx_active = 1'b0;
        if ($urandom_range(0, 299) == 0) txLeft = $urandom_range(1, 30);
      end
      if (enOff > 0) begin
        enable = 1'b0;
        enOff--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 299) == 0) enOff = $urandom_range(1, 10);
      end
      clear_stats = ($urandom_range(0, 499) == 0);
      if ((i / 60) % 3 == 2) piezo_in = ($urandom_range(0, 11) == 0);
      else piezo_in = ($urandom_range(0, 3) == 0);
      reset = (i == 2000);
      tick();
    end
    reset       = 1'b0;
    tx_active   = 1'b0;
    clear_stats = 1'b0;
    piezo_in    = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
